// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: 8N1 UART receiver feeding a first-word-fall-through FIFO.
// The serial line is double-synchronized, decoded by a bit-timer FSM that
// samples mid-bit, and completed bytes are pushed into a DEPTH-entry FIFO.
// Optional carriage-return stripping and sticky overrun/framing flags.
module uart_rx_buffer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  input  logic                     strip_cr,
  input  logic                     rd,
  input  logic                     clr_err,
  output logic [7:0]               rx_char,
  output logic                     rx_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  output logic                     frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [15:0]   BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]   HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;

  // Synchronizer and receiver state
  logic        rx_meta_r;
  logic        rx_sync_r;
  state_t      state_r;
  logic [15:0] timer_r;
  logic [2:0]  bit_idx_r;
  logic [7:0]  shift_r;
  logic        push_r;
  logic [7:0]  push_data_r;

  // FIFO storage and control
  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic          cr_drop_s;
  logic          push_ok_s;
  logic          full_s;
  logic          pop_s;
  logic          wr_en_s;
  logic          ovr_set_s;
  logic [CW-1:0] count_next_s;

  // Bring the asynchronous serial line into the clk domain (idles high).
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Frame decoder: mid-bit sampling, one-cycle push request, sticky framing error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      timer_r     <= 16'd0;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'd0;
      push_r      <= 1'b0;
      push_data_r <= 8'd0;
      frame_err   <= 1'b0;
    end else begin
      push_r <= 1'b0;
      // Clear first so that a framing event in the same cycle takes priority.
      if (clr_err) begin
        frame_err <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (!rx_sync_r) begin
            state_r <= ST_START;
            timer_r <= 16'd0;
          end
        end
        ST_START: begin
          if (timer_r == HALF_LAST) begin
            timer_r <= 16'd0;
            if (rx_sync_r) begin
              state_r <= ST_IDLE;   // too short to be a start bit
            end else begin
              state_r   <= ST_DATA;
              bit_idx_r <= 3'd0;
            end
          end else begin
            timer_r <= timer_r + 16'd1;
          end
        end
        ST_DATA: begin
          if (timer_r == BIT_LAST) begin
            timer_r            <= 16'd0;
            shift_r[bit_idx_r] <= rx_sync_r;
            if (bit_idx_r == 3'd7) begin
              state_r   <= ST_STOP;
              bit_idx_r <= 3'd0;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            timer_r <= timer_r + 16'd1;
          end
        end
        ST_STOP: begin
          if (timer_r == BIT_LAST) begin
            timer_r <= 16'd0;
            if (rx_sync_r) begin
              push_r      <= 1'b1;
              push_data_r <= shift_r;
              state_r     <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state_r   <= ST_WAIT_HIGH;
            end
          end else begin
            timer_r <= timer_r + 16'd1;
          end
        end
        ST_WAIT_HIGH: begin
          // A held-low line (break) must not spawn further frames.
          if (rx_sync_r) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          timer_r <= 16'd0;
        end
      endcase
    end
  end

  // FIFO write/read qualification, including full-with-pop and CR suppression.
  always_comb begin
    cr_drop_s    = strip_cr && (push_data_r == 8'h0D);
    push_ok_s    = push_r && !cr_drop_s;
    full_s       = (count == FULL_CNT);
    pop_s        = rd && rx_valid;
    wr_en_s      = push_ok_s && (!full_s || pop_s);
    ovr_set_s    = push_ok_s && full_s && !pop_s;
    count_next_s = count;
    if (wr_en_s && !pop_s) begin
      count_next_s = count + CNT_ONE;
    end else if (!wr_en_s && pop_s) begin
      count_next_s = count - CNT_ONE;
    end else begin
      count_next_s = count;
    end
  end

  // FIFO storage array; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_data_r;
    end
  end

  // FIFO pointers, occupancy, valid flag and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count    <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count    <= count_next_s;
      rx_valid <= (count_next_s != '0);
      if (ovr_set_s) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
    end
  end

  assign rx_char = mem_r[rd_ptr_r];

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: directed serial frames, scoreboard of expected
// bytes checked by an independent monitor on every accepted read.
module tb_uart_rx_buffer;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       strip_cr;
  logic       rd;
  logic       clr_err;
  logic [7:0] rx_char;
  logic       rx_valid;
  logic [2:0] count;
  logic       overrun;
  logic       frame_err;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  uart_rx_buffer #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .strip_cr (strip_cr),
    .rd       (rd),
    .clr_err  (clr_err),
    .rx_char  (rx_char),
    .rx_valid (rx_valid),
    .count    (count),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor: every accepted read must present the oldest expected byte.
  always @(negedge clk) begin
    if (rst === 1'b0 && rd === 1'b1 && rx_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_pop actual=%02h required=none", rx_char);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rx_char !== mon_exp) begin
          failures++;
          $display("FAIL sb_pop_data actual=%02h required=%02h", rx_char, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame; a low stop bit is followed by 40 more low cycles (break).
  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input bit expect_store);
    if (expect_store) exp_q.push_back(d);
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = d[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx = stop_bit;
    repeat (CPB) @(posedge clk);
    if (!stop_bit) repeat (40) @(posedge clk);
    #1 rx = 1'b1;
    tick(4);
  endtask

  task automatic pop();
    @(posedge clk);
    #1 rd = 1'b1;
    @(posedge clk);
    #1 rd = 1'b0;
  endtask

  task automatic clear_errors();
    @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
  endtask

  // Raise rd exactly on the edge where the FIFO write of a frame started at the same edge lands.
  task automatic rd_on_push();
    @(posedge clk);
    repeat (155) @(posedge clk);
    #1 rd = 1'b1;
    @(posedge clk);
    #1 rd = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; strip_cr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    tick(3);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_count", count, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    tick(2);

    // Single byte round trip
    send_byte(8'h41, 1'b1, 1'b1);
    check("b41_valid", rx_valid, 1);
    check("b41_char", rx_char, 8'h41);
    check("b41_count", count, 1);
    pop();
    check("b41_valid_after_rd", rx_valid, 0);
    check("b41_count_after_rd", count, 0);
    pop();
    check("rd_empty_ignored", count, 0);

    // Carriage-return stripping
    strip_cr = 1'b1;
    send_byte(8'h0D, 1'b1, 1'b0);
    send_byte(8'h0A, 1'b1, 1'b1);
    check("strip_count", count, 1);
    check("strip_char", rx_char, 8'h0A);
    check("strip_no_overrun", overrun, 0);
    pop();
    strip_cr = 1'b0;
    send_byte(8'h0D, 1'b1, 1'b1);
    send_byte(8'h0A, 1'b1, 1'b1);
    check("nostrip_count", count, 2);
    check("nostrip_head", rx_char, 8'h0D);
    pop();
    pop();
    check("nostrip_drained", count, 0);

    // Overrun on a full FIFO
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i), 1'b1, i <= DEPTH);
    end
    check("ovr_count", count, 4);
    check("ovr_flag", overrun, 1);
    for (int i = 0; i < 4; i++) pop();
    check("ovr_drained", count, 0);
    check("ovr_still_sticky", overrun, 1);
    clear_errors();
    check("ovr_cleared", overrun, 0);

    // Framing error with break, then a good byte
    send_byte(8'h55, 1'b0, 1'b0);
    check("ferr_flag", frame_err, 1);
    check("ferr_count", count, 0);
    send_byte(8'hAA, 1'b1, 1'b1);
    check("ferr_next_count", count, 1);
    check("ferr_next_char", rx_char, 8'hAA);
    pop();
    clear_errors();
    check("ferr_cleared", frame_err, 0);

    // Short low glitch is rejected
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(30);
    check("glitch_count", count, 0);
    check("glitch_ferr", frame_err, 0);
    check("glitch_ovr", overrun, 0);

    // Push and read in the same cycle while full
    send_byte(8'h11, 1'b1, 1'b1);
    send_byte(8'h22, 1'b1, 1'b1);
    send_byte(8'h33, 1'b1, 1'b1);
    send_byte(8'h44, 1'b1, 1'b1);
    check("full_count", count, 4);
    fork
      send_byte(8'h99, 1'b1, 1'b1);
      rd_on_push();
    join
    check("full_rdpush_count", count, 4);
    check("full_rdpush_no_ovr", overrun, 0);
    for (int i = 0; i < 4; i++) pop();
    check("full_rdpush_drained", count, 0);

    // Reset mid-frame with flags and data present
    send_byte(8'h66, 1'b0, 1'b0);
    send_byte(8'h77, 1'b1, 1'b0);
    check("pre_rst_ferr", frame_err, 1);
    check("pre_rst_count", count, 1);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(CPB);
    rx = 1'b0;
    tick(8);
    rst = 1'b1;
    tick(2);
    rx = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_count", count, 0);
    check("midrst_valid", rx_valid, 0);
    check("midrst_ovr", overrun, 0);
    check("midrst_ferr", frame_err, 0);
    tick(40);
    check("midrst_no_partial", count, 0);
    send_byte(8'h3C, 1'b1, 1'b1);
    check("post_rst_count", count, 1);
    check("post_rst_char", rx_char, 8'h3C);
    pop();

    tick(4);
    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per serial bit (100 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter DEPTH, default 16, meaning receive FIFO entries; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port strip_cr  input  1  when 1, received 8'h0D bytes are discarded, not stored.
REQ-007 SHALL have port rd  input  1  pop request for head byte.
REQ-008 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-009 SHALL have port rx_char  output  8  FIFO head byte, first-word-fall-through.
REQ-010 SHALL have port rx_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 SHALL have port overrun  output  1  sticky: byte dropped because FIFO full.
REQ-013 SHALL have port frame_err  output  1  sticky: stop bit sampled low.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer; FSM uses only the synchronized value.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HIGH; bit-timer counter and 3-bit bit index.
REQ-016 IDLE: synchronized rx==0 -> START, timer cleared.
REQ-017 START: after CLKS_PER_BIT/2 cycles sample rx; 0 -> DATA with timer cleared, 1 -> IDLE (glitch rejected, nothing stored, no error).
REQ-018 DATA: every CLKS_PER_BIT cycles sample rx into shift register bit index (0 first); after bit 7 -> STOP.
REQ-019 STOP: after CLKS_PER_BIT cycles sample rx; 1 -> push request, IDLE; 0 -> frame_err set, byte discarded, WAIT_HIGH.
REQ-020 WAIT_HIGH: remain until synchronized rx==1, then IDLE (break condition generates no further bytes or errors).
REQ-021 Push SHALL write FIFO in the cycle after the stop sample; rx_valid/count reflect it the following cycle.
REQ-022 Push of 8'h0D while strip_cr==1 SHALL be suppressed: no write, no count change, no overrun.
REQ-023 rd with rx_valid==1 SHALL advance head; rd with rx_valid==0 SHALL be ignored.
REQ-024 rx_char SHALL equal the stored byte at head whenever rx_valid==1; value undefined when empty.
REQ-025 Head and tail pointers SHALL wrap DEPTH-1 -> 0; full is count==DEPTH, empty is count==0.
REQ-026 Push when count==DEPTH and no rd SHALL drop the byte and set overrun; storage unchanged.
REQ-027 Push and rd in the same cycle SHALL both take effect, including when full (count stays DEPTH, no overrun) and when empty (rd ignored, count becomes 1).
REQ-028 clr_err SHALL clear overrun and frame_err next cycle; a set event in the same cycle wins.

Reset
REQ-029 rst SHALL force FSM to IDLE, synchronizer flops to 1, timer/index/shift register to 0, pointers and count to 0, rx_valid=0, overrun=0, frame_err=0.
REQ-030 rst asserted mid-frame SHALL abandon the frame; no partial byte stored; reception restarts on next falling edge after rst deasserts.

Verification (CLKS_PER_BIT=16, DEPTH=4)
REQ-031 Send 8'h41 framed 8N1 -> rx_valid=1, rx_char=8'h41, count=1; pulse rd -> rx_valid=0, count=0.
REQ-032 Send 8'h0D then 8'h0A with strip_cr=1 -> count=1, rx_char=8'h0A; repeat with strip_cr=0 -> count=2, order 0D,0A.
REQ-033 Send 5 bytes 01..05 without rd -> count=4, overrun=1, pops yield 01,02,03,04; clr_err -> overrun=0.
REQ-034 Send 8'h55 with stop bit low, rx held low 40 cycles -> frame_err=1, count=0, no extra bytes; then 8'hAA -> rx_char=8'hAA.
REQ-035 rx low pulse of 4 cycles -> FSM returns IDLE, count=0, no errors.
REQ-036 FIFO full, rd coincident with push of 8'h99 -> count=4, overrun=0, byte 99 popped last; rst during DATA bits -> count=0, all flags 0.
